branch_resolve_unit: RTL

//  EX-stage branch resolver for the RV32I pipeline. Produces the Z/C/V/S compare flags from
//  rs1-rs2, evaluates the funct3 branch condition, checks it against the fetch-time

---
 rtl/branch_resolve_unit.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/branch_resolve_unit.sv
// EX-stage branch resolver: compare flags, funct3 condition, mispredict detection,
// registered PC redirect with a multi-cycle flush, and the 2-bit BHT read by IF.
module branch_resolve_unit #(
  parameter int unsigned XLEN         = 32,
  parameter int unsigned BHT_ENTRIES  = 64,
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ex_valid,
  input  logic [2:0]       ex_funct3,
  input  logic [XLEN-1:0]  ex_rs1,
  input  logic [XLEN-1:0]  ex_rs2,
  input  logic [XLEN-1:0]  ex_pc,
  input  logic [XLEN-1:0]  ex_imm,
  input  logic             ex_pred_taken,
  input  logic [XLEN-1:0]  if_pc,
  output logic             if_pred_taken,
  output logic             redirect_valid,
  output logic [XLEN-1:0]  redirect_pc,
  output logic             flush,
  output logic [CNT_W-1:0] mispredict_cnt
);

  localparam int unsigned IDX  = $clog2(BHT_ENTRIES);
  localparam int unsigned XW1  = XLEN + 1;
  localparam int unsigned FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  typedef enum logic [0:0] {IDLE, FLUSH} state_e;

  state_e            state_q, state_d;
  logic [FC_W-1:0]   fcnt_q, fcnt_d;
  logic              flush_q, flush_d;
  logic              redirect_valid_q, redirect_valid_d;
  logic [XLEN-1:0]   redirect_pc_q, redirect_pc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [1:0]        bht_q [BHT_ENTRIES];

  logic [XW1-1:0]    diff;
  logic              flag_z, flag_c, flag_s, flag_v;
  logic              taken, legal, resolve;
  logic [XLEN-1:0]   target;
  logic [IDX-1:0]    ex_idx, if_idx;
  logic [1:0]        bht_rd;
  logic              bht_we;
  logic [1:0]        bht_wval;
  logic              unused_pc_bits;

  // Compare flags from rs1 - rs2 computed as rs1 + ~rs2 + 1
  assign diff   = {1'b0, ex_rs1} + {1'b0, ~ex_rs2} + XW1'(1);
  assign flag_c = diff[XLEN];
  assign flag_z = (diff[XLEN-1:0] == '0);
  assign flag_s = diff[XLEN-1];
  assign flag_v = (ex_rs1[XLEN-1] != ex_rs2[XLEN-1]) & (diff[XLEN-1] != ex_rs1[XLEN-1]);

  // Branch condition decode; 010/011 are not branches and never resolve
  always_comb begin
    taken = 1'b0;
    legal = 1'b1;
    case (ex_funct3)
      3'b000:  taken = flag_z;
      3'b001:  taken = ~flag_z;
      3'b100:  taken = flag_s ^ flag_v;
      3'b101:  taken = ~(flag_s ^ flag_v);
      3'b110:  taken = ~flag_c;
      3'b111:  taken = flag_c;
      default: legal = 1'b0;
    endcase
  end

  assign resolve = ex_valid & legal & (state_q == IDLE);
  assign target  = taken ? (ex_pc + ex_imm) : (ex_pc + XLEN'(4));

  assign ex_idx        = ex_pc[IDX+1:2];
  assign if_idx        = if_pc[IDX+1:2];
  assign bht_rd        = bht_q[ex_idx];
  assign if_pred_taken = bht_q[if_idx][1];
  assign unused_pc_bits = ^{if_pc[1:0], if_pc[XLEN-1:IDX+2]};

  // Next-state, redirect, counter and BHT update logic
  always_comb begin
    state_d          = state_q;
    fcnt_d           = fcnt_q;
    flush_d          = 1'b0;
    redirect_valid_d = 1'b0;
    redirect_pc_d    = redirect_pc_q;
    cnt_d            = cnt_q;
    bht_we           = 1'b0;
    bht_wval         = bht_rd;
    case (state_q)
      IDLE: begin
        if (resolve) begin
          bht_we = 1'b1;
          if (taken) bht_wval = (bht_rd == 2'b11) ? 2'b11 : bht_rd + 2'b01;
          else       bht_wval = (bht_rd == 2'b00) ? 2'b00 : bht_rd - 2'b01;
          if (taken != ex_pred_taken) begin
            state_d          = FLUSH;
            fcnt_d           = FC_W'(FLUSH_CYCLES - 1);
            flush_d          = 1'b1;
            redirect_valid_d = 1'b1;
            redirect_pc_d    = target;
            if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      FLUSH: begin
        if (fcnt_q == '0) begin
          state_d = IDLE;
        end else begin
          fcnt_d  = fcnt_q - FC_W'(1);
          flush_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q          <= IDLE;
      fcnt_q           <= '0;
      flush_q          <= 1'b0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
      cnt_q            <= '0;
    end else begin
      state_q          <= state_d;
      fcnt_q           <= fcnt_d;
      flush_q          <= flush_d;
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
      cnt_q            <= cnt_d;
    end
  end

  // BHT storage; all entries reset to weakly not-taken
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < BHT_ENTRIES; i++) bht_q[i] <= 2'b01;
    end else if (bht_we) begin
      bht_q[ex_idx] <= bht_wval;
    end
  end

  assign flush          = flush_q;
  assign redirect_valid = redirect_valid_q;
  assign redirect_pc    = redirect_pc_q;
  assign mispredict_cnt = cnt_q;

endmodule
